mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 16, address width.
- DATA_W, 16, word width.
- BLOCK_WORDS, 8, words per cache block, word stride 2 bytes.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache fill request, held until i_done.
- i_addr  in  16  I-cache miss address.
- d_req  in  1  D-cache fill request, held until d_done.
- d_addr  in  16  D-cache miss address.
- d_wr_req  in  1  D-cache write-through request, held until d_wr_ack.
- d_wr_addr  in  16  write address.
- d_wr_data  in  16  write data.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory address.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data.
- mem_data_valid  in  1  read data valid.
- i_grant, d_grant  out  1 each  fill owner indicator.
- i_fill_we, d_fill_we  out  1 each  data-array write enable.
- fill_word  out  3  word index of current return.
- fill_data  out  16  returned word, equal to mem_data_out.
- i_done, d_done  out  1 each  one-cycle pulse; requester writes tag/valid.
- d_wr_ack  out  1  one-cycle write-complete pulse.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, WRITE, ISSUE, DRAIN, DONE, encoded in a registered state vector.
REQ-004 In IDLE, d_wr_req SHALL have highest priority: next state is WRITE.
REQ-005 In IDLE with no write request, a single fill request SHALL win, and the next state is ISSUE.
REQ-006 On a simultaneous i_req and d_req in IDLE, the requester not granted last SHALL win; the last_grant register resets to I, so D wins the first tie.
REQ-007 On the IDLE->ISSUE transition, the block SHALL latch owner and base = addr & 16'hFFF0; later requester address changes SHALL be ignored.
REQ-008 WRITE SHALL last exactly 1 cycle with mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, and d_wr_ack=1, then return to IDLE.
REQ-009 ISSUE SHALL last exactly BLOCK_WORDS cycles with mem_enable=1, mem_wr=0, and mem_addr = base + 2*issue_cnt, where issue_cnt runs 0..7 and the adder wraps modulo 2^16.
REQ-010 After issue_cnt=7, the FSM SHALL go to DRAIN unless all 8 returns are already counted, in which case it goes to DONE.
REQ-011 Returns SHALL be counted in ISSUE and DRAIN:
- On each mem_data_valid, assert the owner's fill_we, set fill_word = ret_cnt, and increment ret_cnt.
REQ-012 When the 8th valid is counted, the next state SHALL be DONE.
REQ-013 DONE SHALL last 1 cycle, pulse the owner's done, update last_grant to the owner, clear both counters, and return to IDLE.
REQ-014 A new request SHALL NOT be granted in DONE; arbitration resumes in IDLE on the following cycle.
REQ-015 The owner's grant SHALL be high from ISSUE entry through DONE; the non-owner's grant, fill_we, and done SHALL be 0.
REQ-016 mem_data_valid SHALL be ignored in IDLE, WRITE, and DONE, and after the 8th return.
REQ-017 When not specified above, mem_enable, mem_wr, and every pulse SHALL be 0, and mem_addr and mem_data_in SHALL be 0.
REQ-018 Latency from request to first mem_enable SHALL be 1 cycle.
REQ-019 With a 4-cycle memory, a full fill SHALL take 13 cycles from ISSUE entry to the done pulse.

Reset
REQ-020 When rst_n=0, the block SHALL go to IDLE asynchronously, with issue_cnt=0, ret_cnt=0, owner=I, last_grant=I, and all outputs 0.
REQ-021 On reset mid-fill, the fill SHALL be abandoned with no done pulse, and returns arriving after reset SHALL be ignored.
REQ-022 The memory model SHALL share rst_n with this block.

Verification
REQ-023 The bench SHALL cover these directed scenarios (4-cycle memory):
- d_req=1, d_addr=16'h1234 -> mem_addr 1230,1232,...,123E on 8 consecutive cycles; d_fill_we with fill_word 0..7; d_done pulse 13 cycles after ISSUE entry.
- i_req and d_req both 1 from reset -> D served first; I served after D's DONE+IDLE; I wins the next tie.
- d_wr_req and i_req simultaneous -> 1-cycle write (mem_wr=1, d_wr_ack pulse), then I fill begins the following cycle.
- i_addr=16'hFFF8 -> mem_addr FFF0..FFFE, with no carry beyond 16 bits.
- rst_n low during ISSUE cycle 3 -> outputs 0 immediately; no i_done; the next request starts a clean fill with fill_word=0.
- mem_data_valid pulsed in IDLE -> no fill_we asserted.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache fill and D write-through memory arbiter
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_req/i_addr                   I-cache block fill request (held until i_done)
//   d_req/d_addr                   D-cache block fill request (held until d_done)
//   d_wr_req/d_wr_addr/d_wr_data   D-cache write-through (held until d_wr_ack)
//   mem_enable/mem_wr/mem_addr/mem_data_in   memory command
//   mem_data_out/mem_data_valid    memory read return
//   i_grant/d_grant                fill owner indicator
//   i_fill_we/d_fill_we            data-array write enable for the returned word
//   fill_word/fill_data            word index and data of the current return
//   i_done/d_done/d_wr_ack         completion pulses
//   busy                           high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           d_req,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_data_in,
  input  logic [DATA_W-1:0]              mem_data_out,
  input  logic                           mem_data_valid,
  output logic                           i_grant,
  output logic                           d_grant,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           i_done,
  output logic                           d_done,
  output logic                           d_wr_ack,
  output logic                           busy
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W:0]    ALL_RET    = (CNT_W + 1)'(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] OFFS_MASK  = ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = D-cache owns the fill
  logic                last_q, last_d;     // 1 = D-cache was granted last
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W:0]      ret_cnt_q, ret_cnt_d;

  logic                mem_enable_q, mem_enable_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                i_grant_q, i_grant_d;
  logic                d_grant_q, d_grant_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic                d_wr_ack_q, d_wr_ack_d;
  logic                busy_q, busy_d;

  logic                fill_hit;
  logic [CNT_W:0]      ret_next;

  // Returns count only while a fill is in flight and not yet complete.
  assign fill_hit = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                    mem_data_valid && (ret_cnt_q < ALL_RET);
  assign ret_next = ret_cnt_q + {{CNT_W{1'b0}}, fill_hit};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (d_wr_req) begin
          state_d = S_WRITE;
        end else if (i_req || d_req) begin
          // On a tie the requester not granted last wins.
          owner_d     = (i_req && d_req) ? ~last_q : d_req;
          base_d      = (owner_d ? d_addr : i_addr) & ~OFFS_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = S_ISSUE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ISSUE: begin
        ret_cnt_d = ret_next;
        if (ret_next == ALL_RET) begin
          state_d = S_DONE;
        end else if (issue_cnt_q == LAST_ISSUE) begin
          state_d = S_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        ret_cnt_d = ret_next;
        if (ret_next == ALL_RET) state_d = S_DONE;
      end
      S_DONE: begin
        last_d      = owner_q;
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Moore outputs are decoded from the next state so they leave flops.
    mem_enable_d  = (state_d == S_WRITE) || (state_d == S_ISSUE);
    mem_wr_d      = (state_d == S_WRITE);
    d_wr_ack_d    = (state_d == S_WRITE);
    mem_addr_d    = '0;
    mem_data_in_d = '0;
    if (state_d == S_WRITE) begin
      mem_addr_d    = d_wr_addr;
      mem_data_in_d = d_wr_data;
    end else if (state_d == S_ISSUE) begin
      mem_addr_d = base_d + ADDR_W'({issue_cnt_d, 1'b0});
    end
    i_grant_d = ((state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_DONE)) && !owner_d;
    d_grant_d = ((state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_DONE)) && owner_d;
    i_done_d  = (state_d == S_DONE) && !owner_d;
    d_done_d  = (state_d == S_DONE) && owner_d;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b0;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      mem_enable_q  <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      i_grant_q     <= 1'b0;
      d_grant_q     <= 1'b0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      d_wr_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      mem_enable_q  <= mem_enable_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      i_grant_q     <= i_grant_d;
      d_grant_q     <= d_grant_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      d_wr_ack_q    <= d_wr_ack_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_enable  = mem_enable_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign i_grant     = i_grant_q;
  assign d_grant     = d_grant_q;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign d_wr_ack    = d_wr_ack_q;
  assign busy        = busy_q;

  // Fill write strobes follow the memory return in the same cycle.
  assign i_fill_we = fill_hit && !owner_q;
  assign d_fill_we = fill_hit && owner_q;
  assign fill_word = fill_hit ? ret_cnt_q[CNT_W-1:0] : '0;
  assign fill_data = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 4-cycle memory
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
  logic        i_grant, d_grant, i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy;
  logic [2:0]  fill_word;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit last_d_model = 1'b0;

  logic [32:0] acc_q[$];   // {wr, addr, wdata}
  logic [20:0] fill_q[$];  // {i_we, d_we, word, data}
  logic [2:0]  done_q[$];  // {i_done, d_done, d_wr_ack}

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hBEEF;
  endfunction

  // Memory: a read accepted in cycle c returns in cycle c+4.
  logic [3:0]  pipe_v;
  logic [15:0] pipe_a [4];
  logic        inject = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int k = 0; k < 4; k++) pipe_a[k] <= '0;
    end else begin
      pipe_v[0] <= mem_enable && !mem_wr;
      pipe_a[0] <= mem_addr;
      for (int k = 1; k < 4; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_a[k] <= pipe_a[k-1];
      end
    end
  end
  assign mem_data_valid = pipe_v[3] | inject;
  assign mem_data_out   = pipe_v[3] ? pat(pipe_a[3]) : (inject ? 16'h5555 : 16'h0000);

  function automatic logic [63:0] all_outs();
    return {3'b0, mem_enable, mem_wr, mem_addr, mem_data_in, i_grant, d_grant,
            i_fill_we, d_fill_we, fill_word, fill_data, i_done, d_done, d_wr_ack, busy};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a fill reads the aligned 8-word block in order and returns it in order.
  task automatic push_fill(input bit is_d, input logic [15:0] addr);
    logic [15:0] base, a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      acc_q.push_back({1'b0, a, 16'h0000});
      fill_q.push_back({!is_d, is_d, 3'(k), pat(a)});
    end
    done_q.push_back(is_d ? 3'b010 : 3'b100);
    last_d_model = is_d;
  endtask

  task automatic flush_model();
    acc_q.delete();
    fill_q.delete();
    done_q.delete();
    last_d_model = 1'b0;
  endtask

  // Monitor: pops expected events whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (mem_enable) begin
        if (acc_q.size() == 0) check("unexpected_mem_access", {mem_wr, mem_addr, mem_data_in}, 64'h1_FFFF_FFFF);
        else check("mem_access", {mem_wr, mem_addr, mem_data_in}, acc_q.pop_front());
        check("busy_on_access", busy, 1);
      end
      if (i_fill_we || d_fill_we) begin
        if (fill_q.size() == 0) check("unexpected_fill", {i_fill_we, d_fill_we, fill_word, fill_data}, 64'h1F_FFFF);
        else check("fill", {i_fill_we, d_fill_we, fill_word, fill_data}, fill_q.pop_front());
        check("fill_grant", {i_grant, d_grant}, {i_fill_we, d_fill_we});
      end
      if (i_done || d_done || d_wr_ack) begin
        if (done_q.size() == 0) check("unexpected_done", {i_done, d_done, d_wr_ack}, 64'hF);
        else check("done", {i_done, d_done, d_wr_ack}, done_q.pop_front());
      end
    end
  end

  // Drive a set of simultaneous requests from idle and hold each until completed.
  task automatic run_batch(input bit wi, input logic [15:0] ia, input bit wd, input logic [15:0] da,
                           input bit ww, input logic [15:0] wa, input logic [15:0] wdat);
    bit fin;
    if (ww) begin
      acc_q.push_back({1'b1, wa, wdat});
      done_q.push_back(3'b001);
    end
    if (wi && wd) begin
      push_fill(!last_d_model, !last_d_model ? da : ia);
      push_fill(!last_d_model, !last_d_model ? da : ia);
    end else if (wi) push_fill(1'b0, ia);
    else if (wd) push_fill(1'b1, da);
    @(negedge clk);
    i_req = wi; i_addr = ia;
    d_req = wd; d_addr = da;
    d_wr_req = ww; d_wr_addr = wa; d_wr_data = wdat;
    fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (i_req && i_grant) i_addr = 16'($urandom);
      if (d_req && d_grant) d_addr = 16'($urandom);
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      if (d_wr_ack) d_wr_req = 1'b0;
      fin = !(i_req || d_req || d_wr_req);
    end
    check("batch_complete", fin, 1);
    i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'hFFF0 | 16'($urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  initial begin
    int  span;
    bit  got;
    bit  seen_bad;
    int  en_cnt;
    bit  hit;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outs(), 64'h0);

    // Tie straight out of reset: D first, then I.
    run_batch(1'b1, 16'h4000, 1'b1, 16'h8008, 1'b0, 16'h0, 16'h0);

    // Directed D fill at 0x1234: latency and span.
    push_fill(1'b1, 16'h1234);
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h1234;
    @(negedge clk);
    check("req_to_enable", mem_enable, 1);
    span = 1; got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      span++;
      if (d_grant) d_addr = 16'($urandom);
      if (d_done) begin
        d_req = 1'b0;
        got = 1'b1;
      end
    end
    check("fill_span", got ? span : 0, 13);
    repeat (2) @(negedge clk);

    // Tie after D was last: I wins.
    run_batch(1'b1, 16'h2222, 1'b1, 16'h3334, 1'b0, 16'h0, 16'h0);

    // Write-through together with an I fill: write goes first.
    run_batch(1'b1, 16'h0100, 1'b0, 16'h0, 1'b1, 16'hABCD, 16'h1357);

    // Block at the top of the address space wraps without carry.
    run_batch(1'b1, 16'hFFF8, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);

    // Stray return while idle.
    @(negedge clk);
    inject = 1'b1;
    #1;
    check("idle_valid_no_we", {i_fill_we, d_fill_we, fill_word}, 64'h0);
    @(negedge clk);
    inject = 1'b0;

    // Reset during the fourth ISSUE cycle.
    push_fill(1'b0, 16'h5670);
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h5670;
    en_cnt = 0; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (mem_enable) en_cnt++;
      if (en_cnt == 4) begin
        rst_n = 1'b0;
        hit = 1'b1;
      end
    end
    check("reached_issue3", hit, 1);
    #1;
    check("async_reset_outputs", all_outs(), 64'h0);
    i_req = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (i_done || d_done || i_fill_we || d_fill_we || mem_enable) seen_bad = 1'b1;
    end
    check("no_activity_after_reset", seen_bad, 0);
    run_batch(1'b1, 16'h9A9A, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);

    // Randomized mixes of simultaneous requests.
    for (int n = 0; n < 30; n++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(1, 7));
      run_batch(sel[0], rand_addr(), sel[1], rand_addr(), sel[2], rand_addr(), 16'($urandom));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", acc_q.size() + fill_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
